// File: rtl/if_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: widths, the zero word
// and the fetch FSM state encoding.
package if_fetch_pkg;

    localparam int AddrLen = 32;
    localparam int InstLen = 32;

    localparam logic [InstLen-1:0] ZERO_WORD = '0;

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_RD0  = 3'd1,
        S_RD1  = 3'd2,
        S_RD2  = 3'd3,
        S_RD3  = 3'd4,
        S_LAST = 3'd5,
        S_OUT  = 3'd6
    } fetch_state_e;

endpackage

// File: rtl/if_fetch.sv
// Instruction fetch: assembles a 4-byte little-endian instruction from four
// byte reads through the memory arbiter and hands it to IF/ID.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter int ADDR_LEN = AddrLen,
    parameter int INST_LEN = InstLen
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [ADDR_LEN-1:0] pc_i,
    input  logic                ce_i,
    input  logic                jump_i,
    input  logic                stall_i,
    output logic                mem_rd_o,
    output logic [ADDR_LEN-1:0] mem_addr_o,
    input  logic                mem_grant_i,
    input  logic [7:0]          mem_data_i,
    output logic [INST_LEN-1:0] inst_o,
    output logic [ADDR_LEN-1:0] inst_pc_o,
    output logic                inst_valid_o,
    output logic                stall_req_o
);

    fetch_state_e          r_state;
    fetch_state_e          w_state_nxt;
    logic [ADDR_LEN-1:0]   r_fetch_addr;
    logic [INST_LEN-1:0]   r_buf;
    logic                  r_pend;
    logic [1:0]            r_pend_idx;
    logic                  w_rd;
    logic [1:0]            w_idx;
    logic                  w_release;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (ce_i)        w_state_nxt = S_RD0;
            S_RD0:   if (mem_grant_i) w_state_nxt = S_RD1;
            S_RD1:   if (mem_grant_i) w_state_nxt = S_RD2;
            S_RD2:   if (mem_grant_i) w_state_nxt = S_RD3;
            S_RD3:   if (mem_grant_i) w_state_nxt = S_LAST;
            S_LAST:                   w_state_nxt = S_OUT;
            S_OUT:   if (!stall_i)    w_state_nxt = S_IDLE;
            default:                  w_state_nxt = S_IDLE;
        endcase
        // A flush wins over every other transition, including the OUT release.
        if (jump_i) begin
            w_state_nxt = S_IDLE;
        end
    end

    always_comb begin
        w_rd        = 1'b0;
        w_idx       = 2'd0;
        stall_req_o = 1'b1;
        case (r_state)
            S_IDLE: stall_req_o = ce_i;
            S_RD0:  begin w_rd = 1'b1; w_idx = 2'd0; end
            S_RD1:  begin w_rd = 1'b1; w_idx = 2'd1; end
            S_RD2:  begin w_rd = 1'b1; w_idx = 2'd2; end
            S_RD3:  begin w_rd = 1'b1; w_idx = 2'd3; end
            S_OUT:  stall_req_o = stall_i;
            default: stall_req_o = 1'b1;
        endcase
        if (!rst) begin
            stall_req_o = 1'b0;
        end
    end

    assign mem_rd_o   = w_rd;
    assign mem_addr_o = w_rd ? (r_fetch_addr + ADDR_LEN'(w_idx)) : '0;
    assign w_release  = (r_state == S_OUT) && !stall_i && !jump_i;

    // Granted byte arrives one cycle later; r_pend/r_pend_idx remember where it goes.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_fetch_addr <= '0;
            r_buf        <= ZERO_WORD;
            r_pend       <= 1'b0;
            r_pend_idx   <= 2'd0;
        end else begin
            if ((r_state == S_IDLE) && ce_i && !jump_i) begin
                r_fetch_addr <= pc_i;
            end
            r_pend     <= w_rd && mem_grant_i && !jump_i;
            r_pend_idx <= w_idx;
            if (r_pend) begin
                r_buf[{r_pend_idx, 3'b000} +: 8] <= mem_data_i;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            inst_o       <= ZERO_WORD;
            inst_pc_o    <= '0;
            inst_valid_o <= 1'b0;
        end else begin
            inst_valid_o <= w_release;
            if (w_release) begin
                inst_o    <= r_buf;
                inst_pc_o <= r_fetch_addr;
            end
        end
    end

endmodule

// File: tb/tb_if_fetch.sv
// Self-checking bench for if_fetch: directed scenarios plus randomized traffic
// against a transaction-level model of the byte-wise fetch.
module tb_if_fetch;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_i;
    logic        ce_i;
    logic        jump_i;
    logic        stall_i;
    logic        mem_rd_o;
    logic [31:0] mem_addr_o;
    logic        mem_grant_i;
    logic [7:0]  mem_data_i;
    logic [31:0] inst_o;
    logic [31:0] inst_pc_o;
    logic        inst_valid_o;
    logic        stall_req_o;

    if_fetch #(.ADDR_LEN(32), .INST_LEN(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .pc_i         (pc_i),
        .ce_i         (ce_i),
        .jump_i       (jump_i),
        .stall_i      (stall_i),
        .mem_rd_o     (mem_rd_o),
        .mem_addr_o   (mem_addr_o),
        .mem_grant_i  (mem_grant_i),
        .mem_data_i   (mem_data_i),
        .inst_o       (inst_o),
        .inst_pc_o    (inst_pc_o),
        .inst_valid_o (inst_valid_o),
        .stall_req_o  (stall_req_o)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: one fetch in flight, counted in bytes granted.
    logic        m_busy;
    logic [31:0] m_addr;
    int          m_cnt;
    logic        m_out;
    logic [31:0] m_word;
    logic        m_valid;
    logic [31:0] m_inst;
    logic [31:0] m_pc;
    int          m_pulses;

    logic        obs_valid;
    int          obs_pulses;
    logic [31:0] addr_log[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        case (a)
            32'h0:   return 8'h13;
            32'h1:   return 8'h05;
            32'h2:   return 8'hA0;
            32'h3:   return 8'h00;
            default: return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h3C;
        endcase
    endfunction

    task automatic model_reset();
        m_busy  = 1'b0;
        m_addr  = 32'h0;
        m_cnt   = 0;
        m_out   = 1'b0;
        m_word  = 32'h0;
        m_valid = 1'b0;
        m_inst  = 32'h0;
        m_pc    = 32'h0;
    endtask

    // One clock cycle: apply inputs, check outputs at negedge, advance model at posedge.
    task automatic cycle(input logic ce, input logic [31:0] pc, input logic jmp,
                         input logic stl, input logic gnt);
        logic        e_rd;
        logic [31:0] e_addr;
        logic        e_stall;
        ce_i        = ce;
        pc_i        = pc;
        jump_i      = jmp;
        stall_i     = stl;
        mem_grant_i = gnt;
        @(negedge clk);
        e_rd    = m_busy && (m_cnt < 4);
        e_addr  = e_rd ? (m_addr + 32'(m_cnt)) : 32'h0;
        e_stall = !m_busy ? ce : !(m_out && !stl);
        chk("mem_rd",     {63'd0, mem_rd_o},     {63'd0, e_rd});
        chk("mem_addr",   {32'd0, mem_addr_o},   {32'd0, e_addr});
        chk("stall_req",  {63'd0, stall_req_o},  {63'd0, e_stall});
        chk("inst_valid", {63'd0, inst_valid_o}, {63'd0, m_valid});
        chk("inst",       {32'd0, inst_o},       {32'd0, m_inst});
        chk("inst_pc",    {32'd0, inst_pc_o},    {32'd0, m_pc});
        obs_valid = inst_valid_o;
        if (inst_valid_o) obs_pulses++;
        if (mem_rd_o) addr_log.push_back(mem_addr_o);
        @(posedge clk);
        m_valid = 1'b0;
        if (jmp) begin
            m_busy = 1'b0;
        end else if (!m_busy) begin
            if (ce) begin
                m_busy = 1'b1;
                m_addr = pc;
                m_cnt  = 0;
                m_out  = 1'b0;
            end
        end else if (m_cnt < 4) begin
            if (gnt) begin
                m_word[8*m_cnt +: 8] = mem_byte(e_addr);
                m_cnt++;
            end
        end else if (!m_out) begin
            m_out = 1'b1;
        end else if (!stl) begin
            m_valid = 1'b1;
            m_inst  = m_word;
            m_pc    = m_addr;
            m_busy  = 1'b0;
            m_pulses++;
        end
        #1;
        mem_data_i = (gnt && e_rd) ? mem_byte(e_addr) : 8'($urandom);
    endtask

    // Starts one fetch (ce only in cycle 0); masks give grant/stall/jump per cycle.
    task automatic run_seq(input logic [31:0] pc, input int n, input logic [31:0] gm,
                           input logic [31:0] sm, input logic [31:0] jm,
                           output int pulse_at, output int npulse);
        pulse_at = -1;
        npulse   = 0;
        addr_log.delete();
        for (int i = 0; i < n; i++) begin
            cycle(i == 0, pc, jm[i], sm[i], gm[i]);
            if (obs_valid) begin
                if (pulse_at < 0) pulse_at = i;
                npulse++;
            end
        end
    endtask

    initial begin
        int pa;
        int np;
        logic [31:0] rpc;
        m_pulses   = 0;
        obs_pulses = 0;
        model_reset();
        rst = 1'b0; ce_i = 1'b1; pc_i = 32'h40; jump_i = 1'b0; stall_i = 1'b0;
        mem_grant_i = 1'b1; mem_data_i = 8'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_mem_rd",    {63'd0, mem_rd_o},     64'd0);
        chk("rst_mem_addr",  {32'd0, mem_addr_o},   64'd0);
        chk("rst_stall_req", {63'd0, stall_req_o},  64'd0);
        chk("rst_valid",     {63'd0, inst_valid_o}, 64'd0);
        chk("rst_inst",      {32'd0, inst_o},       64'd0);
        chk("rst_inst_pc",   {32'd0, inst_pc_o},    64'd0);
        rst = 1'b1;

        // Basic fetch at pc 0, grant every cycle.
        run_seq(32'h0, 8, 32'hFFFF_FFFF, 32'h0, 32'h0, pa, np);
        chk("basic_latency", 64'(pa), 64'd7);
        chk("basic_npulse",  64'(np), 64'd1);
        chk("basic_inst",    {32'd0, inst_o},    64'h00A0_0513);
        chk("basic_pc",      {32'd0, inst_pc_o}, 64'h0);

        // Grant withheld three cycles in RD2 (plus stray grants in IDLE/LAST).
        run_seq(32'h0000_0040, 11, 32'h0000_01C7, 32'h0, 32'h0, pa, np);
        chk("hold_pulse_at", 64'(pa), 64'd10);
        chk("hold_npulse",   64'(np), 64'd1);

        // Jump in RD2 discards the fetch; the next one starts at 0x100.
        run_seq(32'h0000_0080, 6, 32'hFFFF_FFFF, 32'h0, 32'h0000_0008, pa, np);
        chk("jump_no_pulse", 64'(np), 64'd0);
        run_seq(32'h0000_0100, 8, 32'hFFFF_FFFF, 32'h0, 32'h0, pa, np);
        chk("jump_nreq",  64'(addr_log.size()), 64'd4);
        chk("jump_addr0", {32'd0, addr_log[0]}, 64'h100);
        chk("jump_addr1", {32'd0, addr_log[1]}, 64'h101);
        chk("jump_addr2", {32'd0, addr_log[2]}, 64'h102);
        chk("jump_addr3", {32'd0, addr_log[3]}, 64'h103);
        chk("jump_refetch_pulse", 64'(pa), 64'd7);

        // IF/ID stall for four cycles while holding a finished instruction.
        run_seq(32'h0000_0C00, 13, 32'hFFFF_FFFF, 32'h0000_03C0, 32'h0, pa, np);
        chk("stall_pulse_at", 64'(pa), 64'd11);
        chk("stall_npulse",   64'(np), 64'd1);

        // Address wrap at the top of the address space.
        run_seq(32'hFFFF_FFFE, 8, 32'hFFFF_FFFF, 32'h0, 32'h0, pa, np);
        chk("wrap_addr0", {32'd0, addr_log[0]}, 64'hFFFF_FFFE);
        chk("wrap_addr1", {32'd0, addr_log[1]}, 64'hFFFF_FFFF);
        chk("wrap_addr2", {32'd0, addr_log[2]}, 64'h0);
        chk("wrap_addr3", {32'd0, addr_log[3]}, 64'h1);
        chk("wrap_pc",    {32'd0, inst_pc_o},   64'hFFFF_FFFE);

        // Asynchronous reset while in RD1.
        run_seq(32'h0000_0200, 2, 32'hFFFF_FFFF, 32'h0, 32'h0, pa, np);
        ce_i = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("arst_mem_rd",    {63'd0, mem_rd_o},     64'd0);
        chk("arst_mem_addr",  {32'd0, mem_addr_o},   64'd0);
        chk("arst_stall_req", {63'd0, stall_req_o},  64'd0);
        chk("arst_valid",     {63'd0, inst_valid_o}, 64'd0);
        chk("arst_inst",      {32'd0, inst_o},       64'd0);
        chk("arst_inst_pc",   {32'd0, inst_pc_o},    64'd0);
        model_reset();
        @(posedge clk);
        #1;
        chk("arst_hold_stall_req", {63'd0, stall_req_o}, 64'd0);
        chk("arst_hold_mem_rd",    {63'd0, mem_rd_o},    64'd0);
        rst = 1'b1;
        run_seq(32'h0000_0300, 8, 32'hFFFF_FFFF, 32'h0, 32'h0, pa, np);
        chk("arst_refetch_pulse", 64'(pa), 64'd7);
        chk("arst_refetch_pc",    {32'd0, inst_pc_o}, 64'h300);

        // Randomized traffic.
        m_pulses   = 0;
        obs_pulses = 0;
        for (int i = 0; i < 600; i++) begin
            rpc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFFC + 32'($urandom_range(0, 3)))
                                              : $urandom;
            cycle($urandom_range(0, 9) < 8, rpc,
                  $urandom_range(0, 29) == 0,
                  $urandom_range(0, 9) < 3,
                  $urandom_range(0, 9) < 6);
        end
        chk("rand_pulse_count", 64'(obs_pulses), 64'(m_pulses));

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
